// File: rtl/rheed_result_packer.sv
// Packs NUM_PRED prediction words plus timestamp and frame id into one 256-bit beat.
// A second complete result can be parked in the collect buffer while the output beat waits.
module rheed_result_packer #(
   parameter int PIXEL_BIT_WIDTH = 8,
   parameter int NUM_PRED        = 4,
   parameter int OUT_WIDTH       = 256
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       clear,
   input  logic                       s_axis_tvalid,
   output logic                       s_axis_tready,
   input  logic [PIXEL_BIT_WIDTH-1:0] s_axis_tdata,
   output logic                       m_axis_tvalid,
   input  logic                       m_axis_tready,
   output logic [OUT_WIDTH-1:0]       m_axis_tdata,
   output logic                       m_axis_tlast,
   output logic                       pkt_done,
   output logic [15:0]                discard_cnt
);

   localparam int PW    = PIXEL_BIT_WIDTH;
   localparam int DW    = PW * NUM_PRED;
   localparam int IDX_W = (NUM_PRED > 1) ? $clog2(NUM_PRED) : 1;
   localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_PRED - 1);

   generate
      if (OUT_WIDTH != 256) begin : g_bad_out_width
         $error("rheed_result_packer: OUT_WIDTH must be 256");
      end
      if (NUM_PRED < 1 || DW > 192) begin : g_bad_pred_width
         $error("rheed_result_packer: NUM_PRED*PIXEL_BIT_WIDTH must be in 1..192");
      end
   endgenerate

   typedef enum logic {COLLECT, HOLD} state_t;

   state_t           state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [31:0]      cyc_q;
   logic [31:0]      frame_q, frame_d;
   logic [15:0]      disc_q, disc_d;
   logic             ovld_q, ovld_d;
   logic [255:0]     odata_q, odata_d;
   logic             done_q;
   logic [DW-1:0]    buf_q, buf_d;
   logic [31:0]      ts_q, ts_d;
   logic             acc, hs, load, drop;

   function automatic logic [255:0] pack(input logic [DW-1:0] words,
                                         input logic [31:0] ts,
                                         input logic [31:0] frame);
      logic [191:0] field;
      field = '0;
      field[DW-1:0] = words;
      return {frame, ts, field};
   endfunction

   assign acc = s_axis_tvalid && (state_q == COLLECT);
   assign hs  = ovld_q && m_axis_tready;

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      buf_d   = buf_q;
      ts_d    = ts_q;
      frame_d = frame_q;
      disc_d  = disc_q;
      ovld_d  = ovld_q;
      odata_d = odata_q;
      load    = 1'b0;
      drop    = 1'b0;

      if (hs) ovld_d = 1'b0;

      // First word of a result stamps the current cycle, so NUM_PRED=1 gets a same-cycle stamp.
      if (acc) begin
         buf_d[idx_q*PW +: PW] = s_axis_tdata;
         if (idx_q == '0) ts_d = cyc_q;
      end

      case (state_q)
         COLLECT: begin
            if (clear) begin
               idx_d = '0;
               drop  = (idx_q != '0) || acc;
            end else if (acc) begin
               if (idx_q == LAST) begin
                  idx_d = '0;
                  if (!ovld_q || hs) load = 1'b1;
                  else               state_d = HOLD;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end
         end
         HOLD: begin
            if (clear) begin
               state_d = COLLECT;
               drop    = 1'b1;
            end else if (hs) begin
               state_d = COLLECT;
               load    = 1'b1;
            end
         end
         default: state_d = COLLECT;
      endcase

      if (load) begin
         ovld_d  = 1'b1;
         odata_d = pack(buf_d, ts_d, frame_q);
         frame_d = frame_q + 32'd1;
      end
      if (drop && disc_q != 16'hFFFF) disc_d = disc_q + 16'd1;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= COLLECT;
         idx_q   <= '0;
         cyc_q   <= '0;
         frame_q <= '0;
         disc_q  <= '0;
         ovld_q  <= 1'b0;
         odata_q <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         cyc_q   <= cyc_q + 32'd1;
         frame_q <= frame_d;
         disc_q  <= disc_d;
         ovld_q  <= ovld_d;
         odata_q <= odata_d;
         done_q  <= hs;
      end
   end

   // Collect buffer contents are only meaningful behind idx/state, so they carry no reset.
   always_ff @(posedge clk) begin
      buf_q <= buf_d;
      ts_q  <= ts_d;
   end

   assign s_axis_tready = (state_q == COLLECT);
   assign m_axis_tvalid = ovld_q;
   assign m_axis_tlast  = ovld_q;
   assign m_axis_tdata  = odata_q;
   assign pkt_done      = done_q;
   assign discard_cnt   = disc_q;

endmodule

// File: tb/tb_rheed_result_packer.sv
// Bench for rheed_result_packer: transaction-level queue model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic and counter saturation.
module tb_rheed_result_packer;

   localparam int PW = 8;
   localparam int NP = 4;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          clear = 1'b0;
   logic          s_tvalid = 1'b0;
   logic          s_tready;
   logic [PW-1:0] s_tdata = '0;
   logic          m_tvalid;
   logic          m_tready = 1'b0;
   logic [255:0]  m_tdata;
   logic          m_tlast;
   logic          pkt_done;
   logic [15:0]   discard_cnt;

   int ntests = 0;
   int nfail  = 0;

   always #5 clk = ~clk;

   rheed_result_packer #(.PIXEL_BIT_WIDTH(PW), .NUM_PRED(NP), .OUT_WIDTH(256)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .clear        (clear),
      .s_axis_tvalid(s_tvalid),
      .s_axis_tready(s_tready),
      .s_axis_tdata (s_tdata),
      .m_axis_tvalid(m_tvalid),
      .m_axis_tready(m_tready),
      .m_axis_tdata (m_tdata),
      .m_axis_tlast (m_tlast),
      .pkt_done     (pkt_done),
      .discard_cnt  (discard_cnt)
   );

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      ntests++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: words gathered in a queue, one parked result, one output beat.
   int unsigned  cyc_m, frame_m, ts_m, held_ts, disc_m;
   logic [PW-1:0] coll[$];
   bit           held_v, out_v, pd_m;
   logic [191:0] held_d;
   logic [255:0] out_b;

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cyc_m = 0; frame_m = 0; ts_m = 0; disc_m = 0;
         coll.delete();
         held_v = 0; out_v = 0; pd_m = 0; out_b = '0;
      end else begin
         bit acc, hs;
         logic [191:0] d;
         acc  = s_tvalid && !held_v;
         hs   = out_v && m_tready;
         pd_m = hs;
         if (hs) out_v = 0;
         if (clear) begin
            if (held_v) begin
               held_v = 0;
               if (disc_m < 65535) disc_m++;
            end else if (coll.size() > 0 || acc) begin
               coll.delete();
               if (disc_m < 65535) disc_m++;
            end
         end else if (acc) begin
            if (coll.size() == 0) ts_m = cyc_m;
            coll.push_back(s_tdata);
            if (coll.size() == NP) begin
               d = '0;
               foreach (coll[i]) d[i*PW +: PW] = coll[i];
               coll.delete();
               if (!out_v) begin
                  out_b = {frame_m, ts_m, d};
                  out_v = 1;
                  frame_m++;
               end else begin
                  held_v = 1; held_d = d; held_ts = ts_m;
               end
            end
         end else if (held_v && hs) begin
            out_b = {frame_m, held_ts, held_d};
            out_v = 1;
            frame_m++;
            held_v = 0;
         end
         cyc_m++;
      end
   end

   always @(negedge clk) begin
      if (reset_n) begin
         check("m_tvalid",    256'(m_tvalid),    256'(out_v));
         check("m_tlast",     256'(m_tlast),     256'(out_v));
         check("s_tready",    256'(s_tready),    256'(!held_v));
         check("pkt_done",    256'(pkt_done),    256'(pd_m));
         check("discard_cnt", 256'(discard_cnt), 256'(disc_m));
         if (out_v) check("m_tdata", m_tdata, out_b);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset_n  = 1'b0;
      s_tvalid = 1'b0;
      clear    = 1'b0;
      m_tready = 1'b0;
      step();
      step();
      reset_n = 1'b1;
   endtask

   task automatic send(input logic [PW-1:0] w);
      s_tvalid = 1'b1;
      s_tdata  = w;
      step();
      s_tvalid = 1'b0;
   endtask

   initial begin
      int unsigned ts1;

      // Basic beat: 0x11..0x44 with host always ready
      do_reset();
      m_tready = 1'b1;
      ts1 = cyc_m;
      send(8'h11); send(8'h22); send(8'h33); send(8'h44);
      check("t1_tvalid", 256'(m_tvalid), 256'(1));
      check("t1_tlast",  256'(m_tlast),  256'(1));
      check("t1_tdata",  m_tdata, {32'h0, ts1, 160'h0, 32'h44332211});
      step();
      check("t1_pkt_done", 256'(pkt_done), 256'(1));
      check("t1_tvalid_off", 256'(m_tvalid), 256'(0));

      // Back-pressure: 8 words, second result parks in HOLD
      do_reset();
      for (int i = 0; i < 8; i++) send(8'(8'h50 + i));
      check("t2_hold_tready", 256'(s_tready), 256'(0));
      check("t2_frame0", 256'(m_tdata[255:224]), 256'(0));
      check("t2_data0", 256'(m_tdata[31:0]), 256'(32'h53525150));
      step(); step();
      m_tready = 1'b1;
      step();
      check("t2_no_gap", 256'(m_tvalid), 256'(1));
      check("t2_frame1", 256'(m_tdata[255:224]), 256'(1));
      check("t2_data1", 256'(m_tdata[31:0]), 256'(32'h57565554));
      check("t2_tready_back", 256'(s_tready), 256'(1));
      step();
      check("t2_drained", 256'(m_tvalid), 256'(0));

      // Partial result aborted by clear
      do_reset();
      send(8'h01); send(8'h02);
      clear = 1'b1; step(); clear = 1'b0;
      send(8'hA0); send(8'hA1); send(8'hA2); send(8'hA3);
      check("t3_data", 256'(m_tdata[31:0]), 256'(32'hA3A2A1A0));
      check("t3_discard", 256'(discard_cnt), 256'(1));
      check("t3_frame", 256'(m_tdata[255:224]), 256'(0));

      // Clear in HOLD drops the parked result, output beat survives
      do_reset();
      for (int i = 0; i < 8; i++) send(8'(8'hB0 + i));
      clear = 1'b1; step(); clear = 1'b0;
      check("t4_discard", 256'(discard_cnt), 256'(1));
      check("t4_tready", 256'(s_tready), 256'(1));
      check("t4_data", 256'(m_tdata[31:0]), 256'(32'hB3B2B1B0));
      m_tready = 1'b1;
      step();
      check("t4_no_second", 256'(m_tvalid), 256'(0));
      m_tready = 1'b0;

      // Asynchronous reset mid-collection
      do_reset();
      for (int i = 0; i < 4; i++) send(8'(i + 1));
      send(8'h09);
      clear = 1'b1; step(); clear = 1'b0;
      s_tvalid = 1'b1; s_tdata = 8'h77;
      step();
      reset_n = 1'b0;
      #1;
      check("t5_tvalid", 256'(m_tvalid), 256'(0));
      check("t5_tlast",  256'(m_tlast),  256'(0));
      check("t5_tdata",  m_tdata, 256'(0));
      check("t5_pkt_done", 256'(pkt_done), 256'(0));
      check("t5_discard", 256'(discard_cnt), 256'(0));
      check("t5_tready", 256'(s_tready), 256'(1));
      s_tvalid = 1'b0;
      step();
      reset_n = 1'b1;
      send(8'hC0); send(8'hC1); send(8'hC2); send(8'hC3);
      check("t5_frame", 256'(m_tdata[255:224]), 256'(0));
      check("t5_data", 256'(m_tdata[31:0]), 256'(32'hC3C2C1C0));

      // Randomized traffic
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         s_tvalid = ($urandom % 4) != 0;
         s_tdata  = 8'($urandom);
         m_tready = ($urandom % 3) == 0;
         clear    = ($urandom % 40) == 0;
         step();
      end
      s_tvalid = 1'b0; clear = 1'b0; m_tready = 1'b1;
      step(); step();

      // Saturation of the discard counter
      do_reset();
      s_tvalid = 1'b1;
      clear    = 1'b1;
      for (int i = 0; i < 65540; i++) step();
      s_tvalid = 1'b0;
      clear    = 1'b0;
      step();
      check("t6_saturate", 256'(discard_cnt), 256'(16'hFFFF));

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

endmodule
